// File: rtl/rr_arb_2x1.sv
// Two-input round-robin stream arbiter with optional packet-granular grants.
// The granted beat is forwarded through one output register; sel exports the grant to a 2:1 mux.
module rr_arb_2x1 #(
    parameter int WIDTH    = 8,
    parameter bit PKT_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio, prio_nxt;   // 0: A wins a tie in IDLE, 1: B wins
    logic   can_load;
    logic   a_xfer, b_xfer;
    logic   a_end, b_end;

    assign can_load = !y_valid || y_ready;
    assign a_ready  = (state == GRANT_A) && can_load;
    assign b_ready  = (state == GRANT_B) && can_load;
    assign a_xfer   = a_valid && a_ready;
    assign b_xfer   = b_valid && b_ready;
    assign a_end    = a_xfer && (PKT_MODE ? a_last : 1'b1);
    assign b_end    = b_xfer && (PKT_MODE ? b_last : 1'b1);
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can be inferred.
        state_nxt = state;
        prio_nxt  = prio;
        unique case (state)
            IDLE: begin
                if (a_valid && b_valid) state_nxt = prio ? GRANT_B : GRANT_A;
                else if (a_valid)       state_nxt = GRANT_A;
                else if (b_valid)       state_nxt = GRANT_B;
            end
            GRANT_A: begin
                if (a_end) begin
                    prio_nxt  = 1'b1;
                    state_nxt = b_valid ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (b_end) begin
                    prio_nxt  = 1'b0;
                    state_nxt = a_valid ? GRANT_A : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            // sel follows the grant on entry and keeps its last value through IDLE
            if (state_nxt == GRANT_A)      sel <= 1'b0;
            else if (state_nxt == GRANT_B) sel <= 1'b1;
        end
    end

    // NOTE: the data register is reset too, so y_data reads 0 after reset rather than stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
        end else if (a_xfer) begin
            y_valid <= 1'b1;
            y_data  <= a_data;
            y_last  <= PKT_MODE ? a_last : 1'b1;
        end else if (b_xfer) begin
            y_valid <= 1'b1;
            y_data  <= b_data;
            y_last  <= PKT_MODE ? b_last : 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_2x1.sv
// Randomized scoreboard bench for rr_arb_2x1: one instance per PKT_MODE, shared stimulus,
// a link-ownership reference model predicting accepted beats, and a monitor draining the queues.
module tb_rr_arb_2x1;

    localparam int W     = 8;
    localparam int NCYC  = 1000;
    localparam int RSTCY = 700;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    typedef enum int {NONE = 0, OWN_A = 1, OWN_B = 2} owner_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, a_last, b_valid, b_last, y_ready;
    logic [W-1:0] a_data, b_data;

    logic [1:0]   a_ready_v, b_ready_v, y_valid_v, y_last_v, sel_v, busy_v;
    logic [W-1:0] y_data_v [2];

    int n_vec  = 0;
    int n_fail = 0;

    // reference model state, index 0: PKT_MODE=0, index 1: PKT_MODE=1
    owner_t owner [2];
    logic   turn  [2];
    logic   sel_m [2];
    logic   yv_m  [2];
    beat_t  q0[$];
    beat_t  q1[$];

    always #5 clk = ~clk;

    rr_arb_2x1 #(.WIDTH(W), .PKT_MODE(1'b0)) u_m0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready_v[0]),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready_v[0]),
        .y_valid(y_valid_v[0]), .y_data(y_data_v[0]), .y_last(y_last_v[0]), .y_ready(y_ready),
        .sel(sel_v[0]), .busy(busy_v[0])
    );

    rr_arb_2x1 #(.WIDTH(W), .PKT_MODE(1'b1)) u_m1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready_v[1]),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready_v[1]),
        .y_valid(y_valid_v[1]), .y_data(y_data_v[1]), .y_last(y_last_v[1]), .y_ready(y_ready),
        .sel(sel_v[1]), .busy(busy_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int m = 0; m < 2; m++) begin
            owner[m] = NONE;
            turn[m]  = 1'b0;
            sel_m[m] = 1'b0;
            yv_m[m]  = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic check_reset_outputs();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst m%0d a_ready", m), 32'(a_ready_v[m]), 32'd0);
            check($sformatf("rst m%0d b_ready", m), 32'(b_ready_v[m]), 32'd0);
            check($sformatf("rst m%0d y_valid", m), 32'(y_valid_v[m]), 32'd0);
            check($sformatf("rst m%0d y_data", m),  32'(y_data_v[m]),  32'd0);
            check($sformatf("rst m%0d y_last", m),  32'(y_last_v[m]),  32'd0);
            check($sformatf("rst m%0d sel", m),     32'(sel_v[m]),     32'd0);
            check($sformatf("rst m%0d busy", m),    32'(busy_v[m]),    32'd0);
        end
    endtask

    task automatic push_beat(input int m, input beat_t b);
        if (m == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // One cycle of the reference: who owns the link, whether a beat is accepted, and who owns it next.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic  room, ra, rb, moved, pkt;
            beat_t bt;
            pkt   = (m == 1);
            room  = !yv_m[m] || y_ready;
            ra    = (owner[m] == OWN_A) && room;
            rb    = (owner[m] == OWN_B) && room;
            moved = 1'b0;
            check($sformatf("m%0d a_ready", m), 32'(a_ready_v[m]), 32'(ra));
            check($sformatf("m%0d b_ready", m), 32'(b_ready_v[m]), 32'(rb));
            check($sformatf("m%0d busy", m),    32'(busy_v[m]),    32'(owner[m] != NONE));
            check($sformatf("m%0d sel", m),     32'(sel_v[m]),     32'(sel_m[m]));
            if (ra && a_valid) begin
                bt.d = a_data; bt.l = pkt ? a_last : 1'b1;
                push_beat(m, bt);
                moved = 1'b1;
                if (bt.l) begin
                    turn[m]  = 1'b1;
                    owner[m] = b_valid ? OWN_B : NONE;
                end
            end else if (rb && b_valid) begin
                bt.d = b_data; bt.l = pkt ? b_last : 1'b1;
                push_beat(m, bt);
                moved = 1'b1;
                if (bt.l) begin
                    turn[m]  = 1'b0;
                    owner[m] = a_valid ? OWN_A : NONE;
                end
            end else if (owner[m] == NONE) begin
                if (a_valid && b_valid) owner[m] = turn[m] ? OWN_B : OWN_A;
                else if (a_valid)       owner[m] = OWN_A;
                else if (b_valid)       owner[m] = OWN_B;
            end
            if (owner[m] != NONE) sel_m[m] = (owner[m] == OWN_B);
            yv_m[m] = moved ? 1'b1 : (y_ready ? 1'b0 : yv_m[m]);
        end
    endtask

    // Monitor: whatever sits in the output register must match the oldest predicted beat.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                int    sz;
                beat_t f;
                sz = (m == 0) ? q0.size() : q1.size();
                check($sformatf("m%0d y_valid", m), 32'(y_valid_v[m]), 32'(sz != 0));
                if (y_valid_v[m] && sz != 0) begin
                    f = (m == 0) ? q0[0] : q1[0];
                    check($sformatf("m%0d y_data", m), 32'(y_data_v[m]), 32'(f.d));
                    check($sformatf("m%0d y_last", m), 32'(y_last_v[m]), 32'(f.l));
                    if (y_ready) begin
                        if (m == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input int cyc);
        int pv, pl, pr;
        if (cyc < 400)      begin pv = 50;  pl = 30; pr = 75; end
        else if (cyc < 550) begin pv = 100; pl = 50; pr = 100; end
        else if (cyc < 800) begin pv = 70;  pl = 25; pr = ((cyc / 6) % 2 == 0) ? 0 : 90; end
        else                begin pv = 20;  pl = 50; pr = 60; end
        a_valid = ($urandom_range(99) < pv);
        b_valid = ($urandom_range(99) < pv);
        a_last  = ($urandom_range(99) < pl);
        b_last  = ($urandom_range(99) < pl);
        a_data  = W'($urandom);
        b_data  = W'($urandom);
        y_ready = ($urandom_range(99) < pr);
    endtask

    initial begin
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data  = '0;   b_data  = '0;   y_ready = 1'b0;
        rst_n   = 1'b0;
        reset_model();
        #2;
        check_reset_outputs();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(cyc);
            #2;
            model_step();
            if (cyc == RSTCY) begin
                // asynchronous reset between clock edges, with traffic in flight
                #1 rst_n = 1'b0;
                #1 check_reset_outputs();
                reset_model();
                @(negedge clk);
            end
        end
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
